// File: rtl/bcd_scan_counter.sv
// ---------------------------------------------------------------------------
// bcd_scan_counter
//   Multi-digit BCD up/down event counter with a time-multiplexed display
//   scanner feeding a 7-segment decoder (sin) and digit drivers (dig_sel).
//
//   Parameters
//     DIGITS    : number of BCD digits counted and scanned (2..8)
//     SCAN_DIV  : clk cycles per digit slot (>= 2)
//     BLANK_CYC : cycles at the start of each slot with dig_sel forced to 0
//                 (< SCAN_DIV); 0 keeps the scanner in SHOW permanently
//
//   Ports
//     clk      in   system clock, rising edge
//     rst_n    in   asynchronous reset, active low
//     clr      in   synchronous clear of the count (wins over inc)
//     inc      in   count enable, one step per cycle
//     dn       in   direction, 0 = up, 1 = down
//     bcd_val  out  full count, digit 0 in [3:0]
//     wrap     out  one-cycle pulse on roll-over in either direction
//     sin      out  BCD digit currently scanned
//     dig_sel  out  one-hot active-high digit enable
//
//   Optional build macro LEAD_ZERO_BLANK_EN: digits above the most
//   significant non-zero digit are sent as 4'b1111 (decoder blank). Digit 0
//   always shows. Without the macro every digit is shown as-is.
// ---------------------------------------------------------------------------
module bcd_scan_counter #(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  inc,
    input  logic                  dn,
    output logic [4*DIGITS-1:0]   bcd_val,
    output logic                  wrap,
    output logic [3:0]            sin,
    output logic [DIGITS-1:0]     dig_sel
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_LAST = (BLANK_CYC == 0) ? '0 : PW'(BLANK_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} scan_t;

    // ---------------- counter ----------------
    logic [4*DIGITS-1:0] cnt_next;
    logic                wrap_next;
    logic                carry;
    logic [3:0]          dig, dig_new;

    // Ripple carry/borrow across nibbles; the carry out of the top digit
    // is exactly the roll-over condition in both directions.
    always_comb begin
        cnt_next  = bcd_val;
        wrap_next = 1'b0;
        carry     = 1'b0;
        dig       = 4'd0;
        dig_new   = 4'd0;
        if (clr) begin
            cnt_next = '0;
        end else if (inc) begin
            carry = 1'b1;
            for (int i = 0; i < DIGITS; i++) begin
                dig     = bcd_val[i*4 +: 4];
                dig_new = dig;
                if (carry) begin
                    if (!dn) begin
                        if (dig >= 4'd9) dig_new = 4'd0;
                        else begin
                            dig_new = dig + 4'd1;
                            carry   = 1'b0;
                        end
                    end else begin
                        if (dig == 4'd0 || dig > 4'd9) dig_new = 4'd9;
                        else begin
                            dig_new = dig - 4'd1;
                            carry   = 1'b0;
                        end
                    end
                end
                cnt_next[i*4 +: 4] = dig_new;
            end
            wrap_next = carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_val <= '0;
            wrap    <= 1'b0;
        end else begin
            bcd_val <= cnt_next;
            wrap    <= wrap_next;
        end
    end

    // ---------------- scanner ----------------
    logic [PW-1:0] presc, presc_next;
    logic [IW-1:0] idx, idx_next;
    logic          presc_wrap;
    scan_t         state, state_next;
    logic [DIGITS-1:0] dig_sel_next;
    logic [3:0]    sin_next;

    assign presc_wrap = (presc == PRESC_LAST);
    assign presc_next = presc_wrap ? '0 : presc + PW'(1);
    assign idx_next   = !presc_wrap ? idx : ((idx == IDX_LAST) ? '0 : idx + IW'(1));

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BLANK;
            presc <= '0;
            idx   <= '0;
        end else begin
            state <= state_next;
            presc <= presc_next;
            idx   <= idx_next;
        end
    end

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            BLANK: if (BLANK_CYC == 0 || presc == BLANK_LAST) state_next = SHOW;
            SHOW:  if (BLANK_CYC != 0 && presc_wrap)          state_next = BLANK;
            default: state_next = BLANK;
        endcase
    end

    // output logic: decoded from the next state so the registered dig_sel
    // lines up with the state it belongs to
    always_comb begin
        dig_sel_next = '0;
        if (state_next == SHOW) dig_sel_next[idx_next] = 1'b1;
    end

`ifdef LEAD_ZERO_BLANK_EN
    logic [IW-1:0] msd;
    always_comb begin
        msd = '0;
        for (int i = 1; i < DIGITS; i++)
            if (bcd_val[i*4 +: 4] != 4'd0) msd = IW'(i);
        // msd stays 0 for an all-zero count, so digit 0 is never blanked
        sin_next = (idx > msd) ? 4'hF : bcd_val[idx*4 +: 4];
    end
`else
    assign sin_next = bcd_val[idx*4 +: 4];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_sel <= '0;
            sin     <= 4'd0;
        end else begin
            dig_sel <= dig_sel_next;
            sin     <= sin_next;
        end
    end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_scan_counter
//   Self-checking bench for bcd_scan_counter (DIGITS=4, SCAN_DIV=8,
//   BLANK_CYC=2). A decimal-integer reference model tracks the count and a
//   cycle counter since reset derives the expected scan slot.
// ---------------------------------------------------------------------------
module tb_bcd_scan_counter;

    localparam int DIGITS    = 4;
    localparam int SCAN_DIV  = 8;
    localparam int BLANK_CYC = 2;
    localparam int MOD       = 10000;

    logic        clk, rst_n, clr, inc, dn;
    logic [15:0] bcd_val;
    logic        wrap;
    logic [3:0]  sin;
    logic [3:0]  dig_sel;

    bcd_scan_counter #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .inc(inc), .dn(dn),
        .bcd_val(bcd_val), .wrap(wrap), .sin(sin), .dig_sel(dig_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model state
    int m_cnt;     // count as a plain integer
    int m_t;       // rising edges since reset release
    bit m_wrap;
    int m_sin;

    function automatic int digit_of(input int v, input int i);
        return (v / (10 ** i)) % 10;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) r[i*4 +: 4] = 4'(digit_of(v, i));
        return r;
    endfunction

    function automatic int shown_digit(input int v, input int i);
`ifdef LEAD_ZERO_BLANK_EN
        if (i > 0 && v < 10 ** i) return 15;
`endif
        return digit_of(v, i);
    endfunction

    function automatic logic [3:0] exp_dig_sel(input int t);
        logic [3:0] r;
        r = '0;
        if (t % SCAN_DIV >= BLANK_CYC) r[(t / SCAN_DIV) % DIGITS] = 1'b1;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, m_t);
        end
    endtask

    task automatic check_all();
        check("bcd_val", 32'(bcd_val), 32'(to_bcd(m_cnt)));
        check("wrap",    32'(wrap),    32'(m_wrap));
        check("sin",     32'(sin),     32'(m_sin));
        check("dig_sel", 32'(dig_sel), 32'(exp_dig_sel(m_t)));
    endtask

    // one clock: drive inputs, advance model at the edge, compare 1 after
    task automatic step(input bit c, input bit i, input bit d);
        clr = c; inc = i; dn = d;
        @(posedge clk);
        m_sin  = shown_digit(m_cnt, (m_t / SCAN_DIV) % DIGITS);
        m_wrap = 1'b0;
        if (c) m_cnt = 0;
        else if (i && !d) begin
            m_wrap = (m_cnt == MOD - 1);
            m_cnt  = (m_cnt + 1) % MOD;
        end else if (i && d) begin
            m_wrap = (m_cnt == 0);
            m_cnt  = (m_cnt + MOD - 1) % MOD;
        end
        m_t++;
        #1;
        check_all();
    endtask

    task automatic model_reset();
        m_cnt = 0; m_t = 0; m_wrap = 1'b0; m_sin = 0;
    endtask

    typedef struct {
        bit          clr, inc, dn;
        logic [15:0] bcd;
        bit          wrap;
    } vec_t;

    vec_t vec[16];
    logic [15:0] val4321;

    initial begin
        // table of count vectors, applied from a count of 0
        vec[0]  = '{0,1,0,16'h0001,0};
        vec[1]  = '{0,1,0,16'h0002,0};
        vec[2]  = '{0,1,1,16'h0001,0};
        vec[3]  = '{0,1,1,16'h0000,0};
        vec[4]  = '{0,1,1,16'h9999,1};
        vec[5]  = '{0,0,0,16'h9999,0};
        vec[6]  = '{0,1,0,16'h0000,1};
        vec[7]  = '{0,0,1,16'h0000,0};
        vec[8]  = '{0,1,0,16'h0001,0};
        vec[9]  = '{0,1,0,16'h0002,0};
        vec[10] = '{0,1,0,16'h0003,0};
        vec[11] = '{0,1,0,16'h0004,0};
        vec[12] = '{0,1,0,16'h0005,0};
        vec[13] = '{0,1,0,16'h0006,0};
        vec[14] = '{0,1,0,16'h0007,0};
        vec[15] = '{1,1,0,16'h0000,0};   // clr beats inc

        rst_n = 1'b0; clr = 0; inc = 0; dn = 0;
        model_reset();
        #12;
        check("reset_bcd", 32'(bcd_val), 32'h0);
        check("reset_dig_sel", 32'(dig_sel), 32'h0);
        rst_n = 1'b1;

        // reach 0042, then asynchronous reset mid-cycle
        for (int k = 0; k < 42; k++) step(0, 1, 0);
        check("cnt_0042", 32'(bcd_val), 32'h0042);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_bcd", 32'(bcd_val), 32'h0);
        check("async_rst_sin", 32'(sin), 32'h0);
        check("async_rst_dig_sel", 32'(dig_sel), 32'h0);
        check("async_rst_wrap", 32'(wrap), 32'h0);
        model_reset();
        #1 rst_n = 1'b1;

        // first slot: blanked for BLANK_CYC cycles, then digit 0 enabled
        for (int k = 0; k < BLANK_CYC; k++) begin
            step(0, 0, 0);
            if (k < BLANK_CYC - 1) check("first_blank", 32'(dig_sel), 32'h0);
        end
        check("first_show", 32'(dig_sel), 32'h1);

        // table-driven vectors
        step(1, 0, 0);
        for (int k = 0; k < 16; k++) begin
            step(vec[k].clr, vec[k].inc, vec[k].dn);
            check($sformatf("vec%0d_bcd", k), 32'(bcd_val), 32'(vec[k].bcd));
            check($sformatf("vec%0d_wrap", k), 32'(wrap), 32'(vec[k].wrap));
        end
        // clr with a down-step at zero must not roll over
        step(1, 1, 1);
        check("clr_dn_zero_bcd", 32'(bcd_val), 32'h0);
        check("clr_dn_zero_wrap", 32'(wrap), 32'h0);

        // up carry / down borrow
        for (int k = 0; k < 99; k++) step(0, 1, 0);
        check("cnt_0099", 32'(bcd_val), 32'h0099);
        step(0, 1, 0);
        check("carry_0100", 32'(bcd_val), 32'h0100);
        check("carry_0100_wrap", 32'(wrap), 32'h0);
        step(0, 1, 1);
        check("borrow_0099", 32'(bcd_val), 32'h0099);
        step(0, 1, 0);
        for (int k = 0; k < 9899; k++) step(0, 1, 0);
        check("cnt_9999", 32'(bcd_val), 32'h9999);
        step(0, 1, 0);
        check("roll_up_bcd", 32'(bcd_val), 32'h0000);
        check("roll_up_wrap", 32'(wrap), 32'h1);
        step(0, 0, 0);
        check("roll_up_wrap_1cyc", 32'(wrap), 32'h0);

        // scan of 4321: each enabled digit carries its own value
        for (int k = 0; k < 4321; k++) step(0, 1, 0);
        val4321 = 16'h4321;
        for (int k = 0; k < 40; k++) begin
            step(0, 0, 0);
            for (int d = 0; d < DIGITS; d++)
                if (dig_sel == 4'(1 << d))
                    check("scan_4321_sin", 32'(sin), 32'(val4321[d*4 +: 4]));
        end

        // leading-zero behaviour (model follows the build macro)
        step(1, 0, 0);
        for (int k = 0; k < 34; k++) step(0, 0, 0);
        for (int k = 0; k < 50; k++) step(0, 1, 0);
        for (int k = 0; k < 34; k++) step(0, 0, 0);

        // randomized traffic against the model
        for (int k = 0; k < 3000; k++)
            step($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
